debug_trace_buf: RTL and testbench
==================================

// Module: debug_trace_buf
// PURPOSE
// - Parametrised circular trace buffer behind the MMIO debug-display path. Records the last DEPTH words written by the core.
// - Optional trigger with post-trigger capture freezes the buffer. Read-back is indexed relative to the newest entry (index 0 = newest).
// - Sits between mmio_bus_if and the on-board display/UART debug readout.
// PARAMETERS
// - DATA_W    32   width of each captured word
// - DEPTH     32   entry count; power of two, >= 2
// - AW        $clog2(DEPTH)  index width (derived, not overridden)
// - POST_W    AW+1         width of post-trigger length
// PORTS
// - clk          in   1       system clock, rising edge
// - Rst          in   1       asynchronous reset, active-high
// - wea          in   1       capture strobe; one entry per cycle high
// - din          in   DATA_W  word to capture
// - clear        in   1       synchronous flush: pointers, count and state to reset values
// - trig         in   1       trigger pulse; honoured only in RUN
// - post_len     in   POST_W  captures accepted after trigger before freeze (0 = freeze immediately)
// - rd_idx       in   AW      read index, 0 = newest, DEPTH-1 = oldest
// - dout         out  DATA_W  registered entry at rd_idx
// - ts_out       out  32      registered timestamp of entry (DEBUG_TRACE_TSTAMP_EN only)
// - count        out  AW+1    valid entries, saturates at DEPTH
// - wrapped      out  1       sticky: at least one entry overwritten since reset/clear
// - frozen       out  1       high in FROZEN state
// BEHAVIOUR
// - Reset (async, Rst=1): wr_ptr=0, count=0, wrapped=0, state=RUN, post_cnt=0, dout=0, ts_out=0, frozen=0. RAM contents are not reset.
// - FSM states (debug_trace_pkg::state_e):
//   - RUN: wea writes din at wr_ptr, wr_ptr++ (mod DEPTH).
//     - trig & post_len==0 -> FROZEN. A same-cycle wea is still captured.
//     - trig & post_len!=0 -> POST; post_cnt=post_len. A same-cycle wea is captured, but is not counted against post_len.
//   - POST: wea captures and post_cnt--. The capture that brings post_cnt to 0 -> FROZEN. trig is ignored.
//   - FROZEN: wea ignored; no pointer or count change. Read-back stays live.
// - clear has priority over all other inputs: -> RUN with reset values of pointers, count, wrapped and post_cnt. dout is not cleared.
// - count: increments on each accepted write until DEPTH, then holds. wrapped sets on the first accepted write with count==DEPTH.
// - Read: physical address = (wr_ptr - 1 - rd_idx) mod DEPTH (AW-bit wrap arithmetic). dout is valid one cycle after rd_idx is presented (1-cycle latency).
//   - rd_idx >= count: dout=0 (stale RAM is never exposed).
// - Read/write same cycle: the read uses the pre-write wr_ptr. The newly written word becomes index 0 on the next cycle. No bypass.
// - Reset mid-POST: returns to RUN and abandons the capture.
// CONFIGURATION
// - `DEBUG_TRACE_TSTAMP_EN defined:
//   - A free-running 32-bit cycle counter (reset 0, wraps) is stored alongside each accepted write.
//   - ts_out follows the same index/latency rules as dout.
// - Undefined: no counter and no timestamp RAM; ts_out is tied to 0.
// STRUCTURE
// - Package debug_trace_pkg: state_e {RUN, POST, FROZEN}; localparam TS_W=32; function idx2addr().
// - Sub-module trace_ram: simple dual-port RAM, DEPTH x W, sync write, sync read. Instantiated once for data and, when the macro is defined, once for timestamps.
// TESTING
// - Reset, then 5 writes 0x11..0x15 -> count=5, wrapped=0. rd_idx=0 -> dout=0x15 next cycle. rd_idx=4 -> 0x11. rd_idx=5 -> 0.
// - DEPTH=32, 40 writes of values 1..40 -> count=32, wrapped=1; rd_idx=0 -> 40, rd_idx=31 -> 9.
// - post_len=3, trig with wea on 0xA0, then writes 0xA1..0xA5 -> frozen=1 after 0xA3; rd_idx=0 -> 0xA3, rd_idx=1 -> 0xA2.
// - post_len=0, trig alone -> frozen next cycle; further wea leave count and index 0 unchanged. clear -> RUN, count=0.
// - Rst asserted mid-POST without a clock edge -> outputs return to reset values immediately; after release, capture resumes from index 0.
// - With the macro defined: writes at cycles 10 and 13 -> ts_out of rd_idx=1 and rd_idx=0 differ by 3.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// Shared types and helpers for the debug trace buffer.
// Timestamp capture is enabled with `DEBUG_TRACE_TSTAMP_EN.
package debug_trace_pkg;

    typedef enum logic [1:0] {
        RUN,
        POST,
        FROZEN
    } state_e;

    localparam int TS_W = 32;

    // Newest-relative index to physical RAM address, wrapped to the RAM size.
    function automatic logic [31:0] idx2addr(
        input logic [31:0] ptr,
        input logic [31:0] idx,
        input logic [31:0] depth
    );
        return (ptr - 32'd1 - idx) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// Contents are never reset.
module trace_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/debug_trace_buf.sv
// Circular trace buffer with trigger/post-capture freeze and newest-relative read.
// Define `DEBUG_TRACE_TSTAMP_EN to store a cycle timestamp with every capture.
module debug_trace_buf
    import debug_trace_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int POST_W = AW + 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              wea,
    input  logic [DATA_W-1:0] din,
    input  logic              clear,
    input  logic              trig,
    input  logic [POST_W-1:0] post_len,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] dout,
    output logic [31:0]       ts_out,
    output logic [AW:0]       count,
    output logic              wrapped,
    output logic              frozen
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic [POST_W-1:0] post_cnt_q, post_cnt_d;
    logic              rd_ok_q, rd_ok_d;
    logic              we;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] ram_dout;

    assign rd_addr = AW'(idx2addr(32'(wr_ptr_q), 32'(rd_idx), 32'(DEPTH)));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wrapped_d  = wrapped_q;
        post_cnt_d = post_cnt_q;
        we         = 1'b0;
        rd_ok_d    = ({1'b0, rd_idx} < count_q);

        if (clear) begin
            state_d    = RUN;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            post_cnt_d = '0;
        end else begin
            if (wea && state_q != FROZEN) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == FULL) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            unique case (state_q)
                RUN: begin
                    if (trig) begin
                        if (post_len == '0) begin
                            state_d = FROZEN;
                        end else begin
                            state_d    = POST;
                            post_cnt_d = post_len;
                        end
                    end
                end
                POST: begin
                    if (wea) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == POST_W'(1)) begin
                            state_d = FROZEN;
                        end
                    end
                end
                FROZEN: begin
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            post_cnt_q <= '0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            post_cnt_q <= post_cnt_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    trace_ram #(
        .W     (DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_addr),
        .rdata (ram_dout)
    );

    // Entries beyond count gate to zero so stale RAM never leaks out.
    assign dout = rd_ok_q ? ram_dout : '0;

`ifdef DEBUG_TRACE_TSTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] ram_ts;

    assign ts_d = ts_q + 1'b1;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    trace_ram #(
        .W     (TS_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ts_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (ts_q),
        .raddr (rd_addr),
        .rdata (ram_ts)
    );

    assign ts_out = rd_ok_q ? ram_ts : '0;
`else
    assign ts_out = '0;
`endif

    assign count   = count_q;
    assign wrapped = wrapped_q;
    assign frozen  = (state_q == FROZEN);

endmodule

// File: tb/tb_debug_trace_buf.sv
// Scoreboard bench for debug_trace_buf: reads queue expectations from a history model.
// Covers fill, wrap, trigger freeze, clear, async reset and (when enabled) timestamps.
module tb_debug_trace_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int POST_W = AW + 1;

    logic              clk = 1'b0;
    logic              Rst = 1'b1;
    logic              wea = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              clear = 1'b0;
    logic              trig = 1'b0;
    logic [POST_W-1:0] post_len = '0;
    logic [AW-1:0]     rd_idx = '0;
    logic [DATA_W-1:0] dout;
    logic [31:0]       ts_out;
    logic [AW:0]       count;
    logic              wrapped;
    logic              frozen;

    int errors = 0;
    int checks = 0;

    logic [31:0] hist[$];
    logic [31:0] exp_q[$];
    bit          m_frozen;
    int          m_post;
    bit          m_wrapped;

    always #5 clk = ~clk;

    debug_trace_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .wea      (wea),
        .din      (din),
        .clear    (clear),
        .trig     (trig),
        .post_len (post_len),
        .rd_idx   (rd_idx),
        .dout     (dout),
        .ts_out   (ts_out),
        .count    (count),
        .wrapped  (wrapped),
        .frozen   (frozen)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void m_reset();
        hist.delete();
        m_frozen  = 1'b0;
        m_post    = 0;
        m_wrapped = 1'b0;
    endfunction

    function automatic void m_push(input logic [31:0] v);
        if (hist.size() == DEPTH) begin
            void'(hist.pop_front());
            m_wrapped = 1'b1;
        end
        hist.push_back(v);
    endfunction

    function automatic logic [31:0] m_exp(input int idx);
        if (idx < hist.size()) return hist[hist.size() - 1 - idx];
        return 32'h0;
    endfunction

    task automatic wr(input logic [31:0] v);
        wea = 1'b1;
        din = v;
        @(negedge clk);
        wea = 1'b0;
        if (!m_frozen) begin
            m_push(v);
            if (m_post > 0) begin
                m_post--;
                if (m_post == 0) m_frozen = 1'b1;
            end
        end
    endtask

    task automatic fire(input int plen, input bit we, input logic [31:0] v);
        trig     = 1'b1;
        post_len = POST_W'(plen);
        wea      = we;
        din      = v;
        @(negedge clk);
        trig = 1'b0;
        wea  = 1'b0;
        if (we) m_push(v);
        if (plen == 0) m_frozen = 1'b1;
        else m_post = plen;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_reset();
    endtask

    task automatic rd(input string tag, input int idx);
        rd_idx = AW'(idx);
        exp_q.push_back(m_exp(idx));
        @(negedge clk);
        check(tag, dout, exp_q.pop_front());
    endtask

    task automatic status(input string tag);
        check({tag, "_count"}, 32'(count), 32'(hist.size()));
        check({tag, "_wrapped"}, 32'(wrapped), 32'(m_wrapped));
        check({tag, "_frozen"}, 32'(frozen), 32'(m_frozen));
    endtask

    initial begin
        logic [31:0] t0, t1;
        m_reset();
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_frozen", 32'(frozen), 32'd0);
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) wr(32'h11 + 32'(i));
        check("fill5_count", 32'(count), 32'd5);
        check("fill5_wrapped", 32'(wrapped), 32'd0);
        rd("fill5_idx0", 0);
        check("fill5_idx0_const", dout, 32'h15);
        rd("fill5_idx4", 4);
        check("fill5_idx4_const", dout, 32'h11);
        rd("fill5_idx5", 5);

        do_clear();
        status("clr1");
        for (int i = 1; i <= 40; i++) wr(32'(i));
        check("wrap_count", 32'(count), 32'd32);
        check("wrap_flag", 32'(wrapped), 32'd1);
        rd("wrap_idx0", 0);
        check("wrap_idx0_const", dout, 32'd40);
        rd("wrap_idx31", 31);
        check("wrap_idx31_const", dout, 32'd9);
        rd("wrap_idx17", 17);

        do_clear();
        fire(3, 1'b1, 32'hA0);
        wr(32'hA1);
        wr(32'hA2);
        check("post_not_yet", 32'(frozen), 32'd0);
        wr(32'hA3);
        check("post_frozen", 32'(frozen), 32'd1);
        wr(32'hA4);
        wr(32'hA5);
        status("post");
        rd("post_idx0", 0);
        check("post_idx0_const", dout, 32'hA3);
        rd("post_idx1", 1);
        check("post_idx1_const", dout, 32'hA2);
        rd("post_idx3", 3);

        do_clear();
        wr(32'h51);
        wr(32'h52);
        fire(0, 1'b0, 32'h0);
        check("imm_frozen", 32'(frozen), 32'd1);
        wr(32'h99);
        wr(32'h98);
        check("imm_count", 32'(count), 32'd2);
        rd("imm_idx0", 0);
        check("imm_idx0_const", dout, 32'h52);
        do_clear();
        check("imm_clr_frozen", 32'(frozen), 32'd0);
        check("imm_clr_count", 32'(count), 32'd0);

        wr(32'h61);
        fire(4, 1'b0, 32'h0);
        wr(32'h62);
        rd("mid_pre_idx0", 0);
        #2 Rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_frozen", 32'(frozen), 32'd0);
        check("mid_rst_wrapped", 32'(wrapped), 32'd0);
        check("mid_rst_ts", ts_out, 32'd0);
        #1 Rst = 1'b0;
        m_reset();
        @(negedge clk);
        wr(32'h71);
        rd("mid_idx0", 0);
        rd("mid_idx1", 1);
        for (int i = 0; i < 5; i++) wr(32'h72 + 32'(i));
        status("mid_run");
        rd("mid_idx5", 5);

`ifdef DEBUG_TRACE_TSTAMP_EN
        wr(32'hC1);
        @(negedge clk);
        @(negedge clk);
        wr(32'hC2);
        rd_idx = AW'(1);
        @(negedge clk);
        t1 = ts_out;
        rd_idx = AW'(0);
        @(negedge clk);
        t0 = ts_out;
        check("ts_delta", t0 - t1, 32'd3);
`else
        rd("ts_probe", 0);
        t0 = ts_out;
        t1 = 32'h0;
        check("ts_tied", t0, t1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
